stream_stim_gen: RTL and testbench

Self-checking-bench stimulus source: on `start`, it drives a programmed number of pseudo-random data beats into a DUT over a valid/ready stream, with optional random idle gaps. Each accepted beat is mirrored one cycle later on an expected-data port. That port connects directly to the enable/data input of one side of the in-order scoreboard. The DUT output feeds the other side, so the pair closes the check loop.

---
 rtl/stim_pkg.sv | 25 ++
 rtl/stim_lfsr.sv | 29 ++
 rtl/stream_stim_gen.sv | 144 ++++++++++++++
 tb/tb_stream_stim_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// Shared types and LFSR helpers for the stream stimulus generator.
// The Galois LFSR step lives here so the sub-module and the top agree on it.
package stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } stim_state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] SENT_MAX  = 32'h7FFF_FFFF;

  // Right-shifting Galois step: taps fold back in whenever bit 0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // An all-zero state would lock the LFSR, so zero is remapped to one.
  function automatic logic [31:0] seed_fix(input logic [31:0] seed);
    return (seed == 32'h0) ? 32'h1 : seed;
  endfunction

endpackage

// File: rtl/stim_lfsr.sv
// 32-bit Galois LFSR state register with seed load and single-step advance.
// Load together with advance yields the first step from the seed in one edge.
module stim_lfsr
  import stim_pkg::*;
#(
  parameter logic [31:0] RESET_SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        adv,
  output logic [31:0] state
);

  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_SEED;
    end else if (load && adv) begin
      state <= lfsr_next(seed);
    end else if (load) begin
      state <= seed;
    end else if (adv) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/stream_stim_gen.sv
// Valid/ready stimulus source: drives a counted run of LFSR beats with optional
// random idle gaps, and mirrors each accepted beat one cycle later for a scoreboard.
module stream_stim_gen
  import stim_pkg::*;
#(
  parameter int          BITS = 32,
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [15:0]     count,
  input  logic [3:0]      gap_mask,
  output logic            valid,
  input  logic            ready,
  output logic [BITS-1:0] data,
  output logic            exp_en,
  output logic [BITS-1:0] exp_data,
  output logic            busy,
  output logic            done,
  output logic [31:0]     sent
);

  localparam logic [31:0] SEED_EFF = seed_fix(SEED);

  stim_state_e state;
  logic [15:0] remaining;
  logic [3:0]  gap_cnt;
  logic [31:0] lfsr_state;
  logic [31:0] adv_val;
  logic        lfsr_load;
  logic        lfsr_adv;
  logic        fire;
  logic        last_beat;
  logic [3:0]  data_lo;
  logic [3:0]  gap_val;

  // Narrow payloads are zero-extended before the gap nibble is taken.
  generate
    if (BITS >= 4) begin : g_wide
      assign data_lo = data[3:0];
    end else begin : g_narrow
      assign data_lo = 4'(data);
    end
  endgenerate

  assign valid     = (state == SEND);
  assign busy      = (state == SEND) || (state == GAP);
  assign done      = (state == DONE);
  assign fire      = valid && ready;
  assign last_beat = (remaining == 16'd1);
  assign gap_val   = data_lo & gap_mask;
  assign lfsr_load = start && (state == IDLE);

  // Every entry to SEND advances the LFSR exactly once.
  // NOTE: default assigned first so no path through the case leaves a latch.
  always_comb begin
    lfsr_adv = 1'b0;
    case (state)
      IDLE:    lfsr_adv = start && (count != 16'd0);
      SEND:    lfsr_adv = fire && !last_beat && (gap_val == 4'd0);
      GAP:     lfsr_adv = (gap_cnt == 4'd1);
      default: lfsr_adv = 1'b0;
    endcase
  end

  // Same step the LFSR takes this edge, so the payload tracks its new state.
  assign adv_val = lfsr_next(lfsr_load ? SEED_EFF : lfsr_state);

  stim_lfsr #(
    .RESET_SEED (SEED_EFF)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (SEED_EFF),
    .adv   (lfsr_adv),
    .state (lfsr_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= 16'd0;
      gap_cnt   <= 4'd0;
      data      <= '0;
      sent      <= 32'd0;
    end else begin
      if (lfsr_adv) begin
        data <= adv_val[BITS-1:0];
      end
      case (state)
        IDLE: begin
          if (start) begin
            sent <= 32'd0;
            if (count == 16'd0) begin
              state <= DONE;
            end else begin
              state     <= SEND;
              remaining <= count;
            end
          end
        end
        SEND: begin
          if (fire) begin
            if (sent != SENT_MAX) begin
              sent <= sent + 32'd1;
            end
            remaining <= remaining - 16'd1;
            if (last_beat) begin
              state <= DONE;
            end else if (gap_val != 4'd0) begin
              state   <= GAP;
              gap_cnt <= gap_val;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'd1) begin
            state <= SEND;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Registered mirror of the handshake for the expected side of the scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_en   <= 1'b0;
      exp_data <= '0;
    end else begin
      exp_en <= fire;
      if (fire) begin
        exp_data <= data;
      end
    end
  end

endmodule

// File: tb/tb_stream_stim_gen.sv
// Scoreboard bench for stream_stim_gen: a reference model queues the expected beats
// and gaps per run, and an independent monitor pops and compares what the DUT presents.
module tb_stream_stim_gen;

  localparam int          BITS = 32;
  localparam logic [31:0] SEED = 32'h1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [15:0]     count = 16'd0;
  logic [3:0]      gap_mask = 4'd0;
  logic            ready = 1'b0;
  logic            valid;
  logic [BITS-1:0] data;
  logic            exp_en;
  logic [BITS-1:0] exp_data;
  logic            busy;
  logic            done;
  logic [31:0]     sent;

  stream_stim_gen #(
    .BITS (BITS),
    .SEED (SEED)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .count    (count),
    .gap_mask (gap_mask),
    .valid    (valid),
    .ready    (ready),
    .data     (data),
    .exp_en   (exp_en),
    .exp_data (exp_data),
    .busy     (busy),
    .done     (done),
    .sent     (sent)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference LFSR step, straight from the stated recurrence.
  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // Scoreboard state
  logic [31:0] hs_q[$];
  logic [31:0] exp_q[$];
  int          gap_q[$];
  bit          mon_en = 1'b0;
  int          run_count = 0;
  int          hs_cnt = 0;
  int          exp_cnt = 0;
  int          stall_cnt = 0;
  int          idle_cnt = 0;
  int          pend_gap = 0;
  bit          gap_wait = 1'b0;
  bit          expect_done = 1'b0;
  bit          hs_prev = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;

  // Ready driver: forced-low stall window first, then random acceptance.
  int ready_pct = 100;
  int stall_cycles = 0;
  always @(posedge clk) begin
    #1;
    if (stall_cycles > 0) begin
      ready = 1'b0;
      stall_cycles--;
    end else begin
      ready = (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (expect_done) check("done_after_last", 64'({done, busy}), 64'(2'b10));
      else if (done && run_count != 0) check("spurious_done", 64'(done), 64'(0));
      expect_done = 1'b0;

      if (exp_en || hs_prev) check("exp_en_timing", 64'(exp_en), 64'(hs_prev));
      if (exp_en) begin
        if (exp_q.size() == 0) check("exp_extra", 64'(1), 64'(0));
        else check("exp_data", 64'(exp_data), 64'(exp_q.pop_front()));
        exp_cnt++;
      end

      if (gap_wait) begin
        if (valid) begin
          check("gap_len", 64'(idle_cnt), 64'(pend_gap));
          gap_wait = 1'b0;
        end else begin
          check("gap_busy_hold", 64'({busy, data}), 64'({1'b1, prev_data}));
          idle_cnt++;
        end
      end

      if (prev_stall) check("stall_hold", 64'({valid, data}), 64'({1'b1, prev_data}));
      hs_prev    = valid && ready;
      prev_stall = valid && !ready;
      prev_data  = data;
      if (valid && !ready) stall_cnt++;

      if (valid && ready) begin
        if (hs_q.size() == 0) check("hs_extra", 64'(1), 64'(0));
        else check("hs_data", 64'(data), 64'(hs_q.pop_front()));
        hs_cnt++;
        if (hs_cnt == run_count) expect_done = 1'b1;
        else if (gap_q.size() != 0) begin
          pend_gap = gap_q.pop_front();
          gap_wait = 1'b1;
          idle_cnt = 0;
        end
      end
    end
  end

  task automatic reset_mon(input int cnt);
    hs_q.delete();
    exp_q.delete();
    gap_q.delete();
    run_count   = cnt;
    hs_cnt      = 0;
    exp_cnt     = 0;
    stall_cnt   = 0;
    idle_cnt    = 0;
    gap_wait    = 1'b0;
    expect_done = 1'b0;
    hs_prev     = 1'b0;
    prev_stall  = 1'b0;
    mon_en      = 1'b1;
  endtask

  // One run: model the beats and gaps, pulse start, wait for done, check the wrap-up.
  task automatic run(input int cnt, input logic [3:0] mask, input int pct, input int stall,
                     input int poke_at);
    logic [31:0] s;
    logic [31:0] first;
    bit          seen;
    int          cyc;
    @(negedge clk);
    #1;
    reset_mon(cnt);
    s     = SEED;
    first = 32'd0;
    for (int i = 0; i < cnt; i++) begin
      s = model_step(s);
      if (i == 0) first = s;
      hs_q.push_back(s);
      exp_q.push_back(s);
      if (i < cnt - 1) gap_q.push_back(int'(s[3:0] & mask));
    end
    ready_pct    = pct;
    stall_cycles = stall;
    gap_mask     = mask;
    @(posedge clk);
    #1;
    start = 1'b1;
    count = 16'(cnt);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    if (cnt > 0) check("first_cycle", 64'({valid, busy, done, data}), 64'({3'b110, first}));
    else check("first_cycle_empty", 64'({valid, busy, done}), 64'(3'b001));
    seen = done;
    cyc  = 0;
    while (!seen && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = (poke_at != 0) && (cyc == poke_at);
      if (start) count = 16'd5;
      seen = done;
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'(1));
    @(negedge clk);
    #1;
    check("sent", 64'(sent), 64'(cnt));
    check("idle_after", 64'({valid, busy, done, exp_en}), 64'(0));
    check("exp_count", 64'(exp_cnt), 64'(cnt));
    check("hs_count", 64'(hs_cnt), 64'(cnt));
    check("queues_drained", 64'(hs_q.size() + exp_q.size() + gap_q.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 64'({valid, exp_en, busy, done}), 64'(0));
    check({tag, "_data"}, 64'({data, exp_data}), 64'(0));
    check({tag, "_sent"}, 64'(sent), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_seen;
    int cyc;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run(2, 4'h0, 100, 0, 0);
    run(2, 4'hF, 100, 0, 0);
    run(2, 4'h0, 100, 6, 0);
    check("stall_cycles", 64'(stall_cnt), 64'(5));
    run(0, 4'h0, 100, 0, 0);

    // Reset during the third of ten beats; the run is abandoned.
    @(negedge clk);
    #1;
    mon_en    = 1'b0;
    ready_pct = 100;
    gap_mask  = 4'h0;
    @(posedge clk);
    #1;
    start = 1'b1;
    count = 16'd10;
    @(posedge clk);
    #1;
    start   = 1'b0;
    hs_seen = 0;
    cyc     = 0;
    while (hs_seen < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (valid && ready) hs_seen++;
    end
    check("pre_reset_beats", 64'(hs_seen), 64'(2));
    @(posedge clk);
    #2;
    check("third_beat_offered", 64'(valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    check_reset_outputs("mid_rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run(10, 4'h0, 100, 0, 0);

    // Start pulsed mid-run must be ignored.
    run(12, 4'h3, 100, 0, 4);

    for (int r = 0; r < 20; r++) begin
      run(int'($urandom_range(1, 40)), 4'($urandom_range(0, 15)),
          int'($urandom_range(40, 100)), int'($urandom_range(0, 3)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
